// File: rtl/sub_bytes_iter_if.sv
// Handshake bus for sub_bytes_iter: input side, result side and busy flag.
interface sub_bytes_iter_if;
    logic         mode;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    modport slave (
        input  mode, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );

    modport master (
        output mode, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes: LANES S-box lookups per cycle over a 128-bit state,
// result held until downstream accepts.
module s_box_lut (
    input  logic       mode_i,
    input  logic [7:0] data_i,
    output logic [7:0] data_o
);
    // Tables stored entry 0 first (most significant), so entry i sits at 2047-8i.
    localparam logic [2047:0] FWD = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };
    localparam logic [2047:0] INV = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    logic [10:0] idx;
    assign idx    = {~data_i, 3'b111};
    assign data_o = mode_i ? INV[idx -: 8] : FWD[idx -: 8];
endmodule

module sub_bytes_iter #(
    parameter int LANES = 4,
    parameter int BEATS = 16 / LANES
) (
    input  logic             clk,
    input  logic             rst_n,
    sub_bytes_iter_if.slave  bus
);
    localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int W  = LANES * 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [127:0]  data_q,  data_d;
    logic          mode_q,  mode_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    logic [6:0]              base;
    logic [LANES-1:0][7:0]   lane_in;
    wire  [LANES-1:0][7:0]   lane_out;

    // Window of bytes handled on the current beat.
    assign base    = 7'(int'(cnt_q) * W);
    assign lane_in = data_q[base +: W];

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        s_box_lut u_lut (
            .mode_i (mode_q),
            .data_i (lane_in[l]),
            .data_o (lane_out[l])
        );
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: if (bus.in_valid) begin
                data_d  = bus.in_data;
                mode_d  = bus.mode;
                cnt_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                data_d[base +: W] = lane_out;
                if (cnt_q == CW'(BEATS - 1)) state_d = S_DONE;
                else                         cnt_d   = cnt_q + CW'(1);
            end
            S_DONE: if (bus.out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            mode_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.out_data  = data_q;
endmodule
